// File: rtl/type_buffer_pkg.sv
// Shared character codes, default sizes and FSM states for the typing buffer.
package type_buffer_pkg;
    localparam int CH_W  = 5;
    localparam int CNT_W = 15;

    localparam logic [CH_W-1:0] CH_BLANK = 5'd0;
    localparam logic [CH_W-1:0] CH_A     = 5'd1;
    localparam logic [CH_W-1:0] CH_Z     = 5'd26;
    localparam logic [CH_W-1:0] CH_SPACE = 5'd27;
    localparam logic [CH_W-1:0] CH_BKSP  = 5'd28;

    localparam int MAXLEN_DEF = 25;
    localparam int WLEN_DEF   = 15;

    typedef enum logic [1:0] {TYPING, CHECK, CLEAR} state_e;
endpackage

// File: rtl/type_buffer_prefix_match.sv
// Leading-run match count of typed characters against the target word, capped at target_len.
module prefix_match
    import type_buffer_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int WLEN   = WLEN_DEF
) (
    input  logic [CH_W*MAXLEN-1:0] type_i,
    input  logic [CH_W*WLEN-1:0]   target_i,
    input  logic [CH_W-1:0]        target_len_i,
    output logic [CH_W-1:0]        count_o
);
    localparam int L = MAXLEN + WLEN;

    // Both operands padded with blanks to a common length so every position compares in range.
    logic [CH_W*L-1:0] type_ext, tgt_ext;
    assign type_ext = {{(CH_W*WLEN){1'b0}}, type_i};
    assign tgt_ext  = {{(CH_W*MAXLEN){1'b0}}, target_i};

    int   cnt;
    logic run;

    always_comb begin
        cnt = 0;
        run = 1'b1;
        for (int i = 0; i < L; i++) begin
            if (run && type_ext[CH_W*i +: CH_W] == tgt_ext[CH_W*i +: CH_W]) cnt = cnt + 1;
            else run = 1'b0;
        end
        count_o = (cnt > int'(target_len_i)) ? target_len_i : CH_W'(cnt);
    end
endmodule

// File: rtl/type_buffer.sv
// Typing buffer with word submit/check/clear FSM and keystroke/error counters.
// Optional backspace support enabled by macro TYPE_BUFFER_BACKSPACE_EN.
module type_buffer
    import type_buffer_pkg::*;
#(
    parameter int MAXLEN = MAXLEN_DEF,
    parameter int WLEN   = WLEN_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   key_valid_i,
    input  logic [CH_W-1:0]        key_code_i,
    output logic                   key_ready_o,
    input  logic [CH_W*WLEN-1:0]   target_i,
    input  logic [CH_W-1:0]        target_len_i,
    output logic [CH_W*MAXLEN-1:0] type_o,
    output logic [CH_W-1:0]        tot_o,
    output logic [CH_W-1:0]        correct_o,
    output logic                   word_done_o,
    output logic                   word_ok_o,
    output logic [CNT_W-1:0]       keystrokes_o,
    output logic [CNT_W-1:0]       errors_o
);
    localparam logic [CH_W-1:0]  MAXLEN_C = CH_W'(MAXLEN);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_e                   state_q, state_d;
    logic [CH_W*MAXLEN-1:0]   type_q, type_d;
    logic [CH_W-1:0]          tot_q, tot_d, correct_q, match_cnt;
    logic [CNT_W-1:0]         ks_q, ks_d, err_q, err_d;

    logic [CH_W*(MAXLEN+WLEN)-1:0] tgt_ext;
    logic [CH_W-1:0]               tgt_at;
    logic                          accept, is_letter, letter_err;

    prefix_match #(.MAXLEN(MAXLEN), .WLEN(WLEN)) u_match (
        .type_i      (type_q),
        .target_i    (target_i),
        .target_len_i(target_len_i),
        .count_o     (match_cnt)
    );

    // Positions past the target word read as blank, so any letter there mismatches.
    assign tgt_ext    = {{(CH_W*MAXLEN){1'b0}}, target_i};
    assign tgt_at     = tgt_ext[CH_W*tot_q +: CH_W];
    assign key_ready_o = rst_ni && (state_q == TYPING);
    assign accept     = key_valid_i && key_ready_o;
    assign is_letter  = (key_code_i >= CH_A) && (key_code_i <= CH_Z);
    assign letter_err = (tot_q >= target_len_i) || (key_code_i != tgt_at);

    always_comb begin
        state_d = state_q;
        type_d  = type_q;
        tot_d   = tot_q;
        ks_d    = ks_q;
        err_d   = err_q;
        case (state_q)
            TYPING: begin
                if (accept) begin
                    if (is_letter) begin
                        if (tot_q < MAXLEN_C) begin
                            type_d[CH_W*tot_q +: CH_W] = key_code_i;
                            tot_d = tot_q + CH_W'(1);
                        end
                        if (ks_q != CNT_MAX) ks_d = ks_q + CNT_W'(1);
                        if (letter_err && err_q != CNT_MAX) err_d = err_q + CNT_W'(1);
                    end else if (key_code_i == CH_SPACE) begin
                        if (tot_q != '0) state_d = CHECK;
                    end
`ifdef TYPE_BUFFER_BACKSPACE_EN
                    else if (key_code_i == CH_BKSP && tot_q != '0) begin
                        type_d[CH_W*(tot_q - CH_W'(1)) +: CH_W] = CH_BLANK;
                        tot_d = tot_q - CH_W'(1);
                    end
`endif
                end
            end
            CHECK:   state_d = CLEAR;
            CLEAR: begin
                type_d  = '0;
                tot_d   = '0;
                state_d = TYPING;
            end
            default: state_d = TYPING;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= TYPING;
            type_q    <= '0;
            tot_q     <= '0;
            correct_q <= '0;
            ks_q      <= '0;
            err_q     <= '0;
        end else begin
            state_q   <= state_d;
            type_q    <= type_d;
            tot_q     <= tot_d;
            correct_q <= match_cnt;
            ks_q      <= ks_d;
            err_q     <= err_d;
        end
    end

    // Gated by reset so a reset landing in CHECK never shows a done pulse.
    assign word_done_o  = rst_ni && (state_q == CHECK);
    assign word_ok_o    = word_done_o && (tot_q == target_len_i) && (correct_q == target_len_i);
    assign type_o       = type_q;
    assign tot_o        = tot_q;
    assign correct_o    = correct_q;
    assign keystrokes_o = ks_q;
    assign errors_o     = err_q;
endmodule

// File: tb/tb_type_buffer.sv
// Bench for type_buffer: directed word scenarios plus random keys against a behavioural model.
module tb_type_buffer;
    import type_buffer_pkg::*;
    localparam int ML = MAXLEN_DEF;
    localparam int WL = WLEN_DEF;

    logic            clk = 1'b0, rst_n = 1'b0, kv = 1'b0;
    logic [4:0]      kc = '0;
    logic            kr, wd, wo;
    logic [5*WL-1:0] tvec;
    logic [4:0]      tlen_v;
    logic [5*ML-1:0] typ;
    logic [4:0]      tot, cor;
    logic [14:0]     ks, er;

    int tgt[WL];
    int tlen = 0;
    int total = 0, bad = 0;
    bit model_on = 0;

    // model: typed letters, count, pending check/clear countdown, registered match, counters
    int m_type[ML];
    int m_tot = 0, m_busy = 0, m_cor = 0, m_ks = 0, m_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        tvec = '0;
        for (int i = 0; i < WL; i++) tvec[5*i +: 5] = 5'(tgt[i]);
    end
    assign tlen_v = 5'(tlen);

    type_buffer dut (
        .clk_i(clk), .rst_ni(rst_n), .key_valid_i(kv), .key_code_i(kc), .key_ready_o(kr),
        .target_i(tvec), .target_len_i(tlen_v), .type_o(typ), .tot_o(tot), .correct_o(cor),
        .word_done_o(wd), .word_ok_o(wo), .keystrokes_o(ks), .errors_o(er)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic int mprefix();
        int n = 0;
        for (int i = 0; i < ML && i < tlen; i++) begin
            if (m_type[i] != ((i < WL) ? tgt[i] : 0)) break;
            n++;
        end
        return n;
    endfunction

    function automatic logic [127:0] mvec();
        logic [127:0] v = '0;
        for (int i = 0; i < ML; i++) v[5*i +: 5] = 5'(m_type[i]);
        return v;
    endfunction

    // Inputs are stable from posedge+1 to the next posedge, so the negedge sees what that edge samples.
    task automatic model_step();
        int nc, t;
        bit err;
        nc = mprefix();
        if (!rst_n) begin
            foreach (m_type[i]) m_type[i] = 0;
            m_tot = 0; m_busy = 0; m_ks = 0; m_err = 0; nc = 0;
        end else if (m_busy == 2) begin
            m_busy = 1;
        end else if (m_busy == 1) begin
            foreach (m_type[i]) m_type[i] = 0;
            m_tot = 0; m_busy = 0;
        end else if (kv) begin
            if (kc >= 1 && kc <= 26) begin
                t = (m_tot < WL) ? tgt[m_tot] : 0;
                err = (m_tot >= tlen) || (int'(kc) != t);
                if (m_tot < ML) begin m_type[m_tot] = int'(kc); m_tot++; end
                if (m_ks < 32767) m_ks++;
                if (err && m_err < 32767) m_err++;
            end else if (kc == 27) begin
                if (m_tot > 0) m_busy = 2;
            end
`ifdef TYPE_BUFFER_BACKSPACE_EN
            else if (kc == 28 && m_tot > 0) begin
                m_tot--; m_type[m_tot] = 0;
            end
`endif
        end
        m_cor = nc;
    endtask

    always @(negedge clk) begin
        if (model_on) begin
            chk("key_ready", kr, rst_n && m_busy == 0);
            chk("word_done", wd, rst_n && m_busy == 2);
            chk("word_ok", wo, rst_n && m_busy == 2 && m_tot == tlen && m_cor == tlen);
            chk("type", typ, mvec());
            chk("tot", tot, m_tot);
            chk("correct", cor, m_cor);
            chk("keystrokes", ks, m_ks);
            chk("errors", er, m_err);
        end
        model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input int c);
        kv = 1'b1; kc = 5'(c);
        tick();
        kv = 1'b0; kc = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic set_cat();
        foreach (tgt[i]) tgt[i] = 0;
        tgt[0] = 3; tgt[1] = 1; tgt[2] = 20; tlen = 3;
    endtask

    initial begin
        int r;
        set_cat();
        tick(); tick();
        model_on = 1;
        chk("rst_tot", tot, 0);
        chk("rst_ks", ks, 0);
        chk("rst_ready_low", kr, 0);
        rst_n = 1'b1;
        #1 chk("ready_after_rst", kr, 1);

        // CAT typed correctly
        key(3); key(1); key(20); key(27);
        chk("cat_done", wd, 1); chk("cat_ok", wo, 1);
        chk("cat_tot", tot, 3); chk("cat_correct", cor, 3);
        tick();
        chk("cat_done_1cyc", wd, 0);
        tick();
        chk("cat_clr_tot", tot, 0); chk("cat_clr_type", typ, 0); chk("cat_ready", kr, 1);

        // COT against CAT
        do_reset();
        key(3); key(15); key(20); tick();
        chk("cot_correct", cor, 1); chk("cot_err", er, 1); chk("cot_ks", ks, 3);
        key(27);
        chk("cot_done", wd, 1); chk("cot_ok", wo, 0);
        tick(); tick();

        // overflow past MAXLEN
        do_reset();
        for (int c = 1; c <= 26; c++) key(c);
        chk("full_tot", tot, 25); chk("full_slot24", typ[24*5 +: 5], 25); chk("full_ks", ks, 26);

        // backspace handling
        do_reset();
        key(3); key(24); key(28); key(1); key(20); tick();
`ifdef TYPE_BUFFER_BACKSPACE_EN
        chk("bksp_type", typ, {5'd20, 5'd1, 5'd3}); chk("bksp_correct", cor, 3);
`else
        chk("bksp_type", typ, {5'd20, 5'd1, 5'd24, 5'd3}); chk("bksp_tot", tot, 4);
`endif

        // key held through CHECK and CLEAR
        do_reset();
        key(3);
        kv = 1'b1; kc = 5'd27; tick();
        chk("hold_check_ready", kr, 0); chk("hold_check_done", wd, 1);
        kc = 5'd1; tick();
        chk("hold_clear_ready", kr, 0);
        tick();
        chk("hold_typing_ready", kr, 1); chk("hold_tot0", tot, 0); chk("hold_ks1", ks, 1);
        tick();
        kv = 1'b0; kc = '0;
        chk("hold_tot1", tot, 1); chk("hold_ks2", ks, 2);

        // reset during CHECK
        do_reset();
        key(3); key(1); key(20); key(27);
        rst_n = 1'b0;
        #1 chk("abort_done", wd, 0); chk("abort_ready", kr, 0);
        tick();
        chk("abort_tot", tot, 0); chk("abort_type", typ, 0); chk("abort_correct", cor, 0);
        chk("abort_ks", ks, 0); chk("abort_wd", wd, 0); chk("abort_wo", wo, 0);
        rst_n = 1'b1;
        #1 chk("abort_ready_back", kr, 1);
        tick();

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) < 2) begin
                tlen = $urandom_range(0, WL);
                foreach (tgt[i]) tgt[i] = (i < tlen) ? int'($urandom_range(1, 26)) : 0;
            end
            rst_n = ($urandom_range(0, 199) != 0);
            kv = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 99);
            if (r < 5) kc = 5'd27;
            else if (r < 10) kc = 5'd28;
            else if (r < 13) kc = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'($urandom_range(29, 31));
            else if (r < 65 && m_tot < tlen) kc = 5'(tgt[m_tot]);
            else kc = 5'($urandom_range(1, 26));
            tick();
        end
        kv = 1'b0; rst_n = 1'b1;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
